// File: rtl/mem_march_bist.sv
// March C- BIST controller for one read-first synchronous RAM port (M0 w0, M1..M4 r/w pairs, M5 r0).
// Optional error log (err_addr/err_count) is enabled by defining BIST_ERRLOG_EN.
module mem_march_bist #(
    parameter int ABITS = 12,
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mem_wren,
    output logic             mem_rden,
    output logic [ABITS-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [ABITS-1:0] err_addr,
    output logic [15:0]      err_count
);
    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5, FIN} state_t;

    localparam logic [ABITS-1:0] ADDR_MAX = '1;
    localparam logic [WIDTH-1:0] ONES     = '1;

    state_t           state_reg, state_next;
    logic [ABITS-1:0] addr_next;
    logic             phase_reg, phase_next;
    logic             m5_rd_reg;
    logic [ABITS-1:0] prev_addr_reg;
    logic             err_seen_reg;
    logic             rw_next, wr_next, rd_next;
    logic             cmp_en, mismatch, start_ok;
    logic [WIDTH-1:0] cmp_exp;
    logic [ABITS-1:0] cmp_addr;

    // Sequencer: phase 0 is the read cycle, phase 1 the write/compare cycle of a r/w element.
    always_comb begin
        state_next = state_reg;
        addr_next  = mem_addr;
        phase_next = 1'b0;
        case (state_reg)
            IDLE: if (start) begin
                state_next = M0;
                addr_next  = '0;
            end
            M0: if (mem_addr == ADDR_MAX) begin
                state_next = M1;
                addr_next  = '0;
            end else begin
                addr_next = mem_addr + 1'b1;
            end
            M1, M2: if (!phase_reg) begin
                phase_next = 1'b1;
            end else if (mem_addr == ADDR_MAX) begin
                state_next = (state_reg == M1) ? M2 : M3;
                addr_next  = (state_reg == M1) ? '0 : ADDR_MAX;
            end else begin
                addr_next = mem_addr + 1'b1;
            end
            M3, M4: if (!phase_reg) begin
                phase_next = 1'b1;
            end else if (mem_addr == '0) begin
                state_next = (state_reg == M3) ? M4 : M5;
                addr_next  = (state_reg == M3) ? ADDR_MAX : '0;
            end else begin
                addr_next = mem_addr - 1'b1;
            end
            M5: if (mem_addr == ADDR_MAX) begin
                state_next = FIN;
                addr_next  = '0;
            end else begin
                addr_next = mem_addr + 1'b1;
            end
            FIN: begin
                state_next = IDLE;
                addr_next  = '0;
            end
            default: begin
                state_next = IDLE;
                addr_next  = '0;
            end
        endcase
    end

    always_comb begin
        rw_next = (state_next == M1) || (state_next == M2) || (state_next == M3) || (state_next == M4);
        wr_next = (state_next == M0) || (rw_next && phase_next);
        rd_next = (state_next == M5) || (rw_next && !phase_next);
    end

    // M5 reads are compared one cycle late, so FIN carries the final compare.
    always_comb begin
        cmp_en   = 1'b0;
        cmp_exp  = '0;
        cmp_addr = mem_addr;
        if ((state_reg == M1 || state_reg == M2 || state_reg == M3 || state_reg == M4) && phase_reg) begin
            cmp_en  = 1'b1;
            cmp_exp = (state_reg == M2 || state_reg == M4) ? ONES : '0;
        end else if (m5_rd_reg) begin
            cmp_en   = 1'b1;
            cmp_addr = prev_addr_reg;
        end
        mismatch = cmp_en && (mem_rdata != cmp_exp);
        start_ok = (state_reg == IDLE) && start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            phase_reg     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            mem_wren      <= 1'b0;
            mem_rden      <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            m5_rd_reg     <= 1'b0;
            prev_addr_reg <= '0;
            err_seen_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            busy          <= (state_next != IDLE);
            done          <= (state_reg == FIN);
            mem_wren      <= wr_next;
            mem_rden      <= rd_next;
            mem_addr      <= addr_next;
            mem_wdata     <= (wr_next && (state_next == M1 || state_next == M3)) ? ONES : '0;
            m5_rd_reg     <= (state_reg == M5);
            prev_addr_reg <= mem_addr;
            if (start_ok) begin
                pass         <= 1'b0;
                err_seen_reg <= 1'b0;
            end else if (mismatch) begin
                err_seen_reg <= 1'b1;
            end
            if (state_reg == FIN)
                pass <= !(err_seen_reg || mismatch);
        end
    end

`ifdef BIST_ERRLOG_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_addr  <= '0;
            err_count <= '0;
        end else if (mismatch) begin
            if (err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
            if (!err_seen_reg)
                err_addr <= cmp_addr;
        end
    end
`else
    assign err_addr  = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_mem_march_bist.sv
// Randomized self-checking bench for mem_march_bist (ABITS=4) with a faultable read-first RAM model.
module tb_mem_march_bist;
    localparam int ABITS = 4;
    localparam int WIDTH = 72;
    localparam int N     = 16;
    localparam logic [WIDTH-1:0] ONES = '1;

    logic             clk = 1'b0;
    logic             rst, start;
    logic             busy, done, pass, mem_wren, mem_rden;
    logic [ABITS-1:0] mem_addr, err_addr;
    logic [WIDTH-1:0] mem_wdata, mem_rdata;
    logic [15:0]      err_count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] ram [N];
    logic             fault_en;
    logic [ABITS-1:0] fault_addr;
    int               fault_bit;
    logic             fault_val;
    logic [77:0]      exp_ops[$];

    always #5 clk = ~clk;

    mem_march_bist #(.ABITS(ABITS), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err_addr(err_addr), .err_count(err_count)
    );

    function automatic logic [WIDTH-1:0] faulty(input logic [WIDTH-1:0] v, input logic [ABITS-1:0] a);
        logic [WIDTH-1:0] r;
        r = v;
        if (fault_en && a == fault_addr) r[fault_bit] = fault_val;
        return r;
    endfunction

    // Read-first synchronous RAM with an optional stuck-at bit on the read path.
    always @(posedge clk) begin
        if (mem_rden) mem_rdata <= faulty(ram[mem_addr], mem_addr);
        if (mem_wren) ram[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected bus sequence and outcome, built directly from the march element list.
    task automatic build_model(output int nerr, output logic [ABITS-1:0] first);
        logic [WIDTH-1:0] m [N];
        logic [WIDTH-1:0] ev, wv, v;
        logic [ABITS-1:0] a;
        nerr  = 0;
        first = '0;
        exp_ops.delete();
        for (int k = 0; k < N; k++) begin
            a = ABITS'(k);
            m[k] = '0;
            exp_ops.push_back({1'b1, 1'b0, a, {WIDTH{1'b0}}});
        end
        for (int e = 1; e <= 4; e++) begin
            ev = (e == 2 || e == 4) ? ONES : '0;
            wv = ~ev;
            for (int k = 0; k < N; k++) begin
                a = (e <= 2) ? ABITS'(k) : ABITS'(N - 1 - k);
                exp_ops.push_back({1'b0, 1'b1, a, {WIDTH{1'b0}}});
                exp_ops.push_back({1'b1, 1'b0, a, wv});
                v = faulty(m[a], a);
                if (v !== ev) begin
                    if (nerr == 0) first = a;
                    nerr++;
                end
                m[a] = wv;
            end
        end
        for (int k = 0; k < N; k++) begin
            a = ABITS'(k);
            exp_ops.push_back({1'b0, 1'b1, a, {WIDTH{1'b0}}});
            v = faulty(m[a], a);
            if (v !== '0) begin
                if (nerr == 0) first = a;
                nerr++;
            end
        end
        exp_ops.push_back(78'd0);
    endtask

    task automatic do_run(input string name, input int abort_at, input bit poke_start);
        int nerr, idx, busy_cycles, dones, seen;
        logic [ABITS-1:0] first;
        logic [15:0] exp_cnt;
        logic [ABITS-1:0] exp_ea;
        bit finished;
        build_model(nerr, first);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        idx = 0; busy_cycles = 0; dones = 0; finished = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (busy) begin
                busy_cycles++;
                if (busy_cycles == 1) chk({name, "_pass_clr"}, pass, 1'b0);
                chk({name, "_overlap"}, mem_wren & mem_rden, 1'b0);
                if (idx < exp_ops.size())
                    chk($sformatf("%s_op%0d", name, idx), {mem_wren, mem_rden, mem_addr, mem_wdata}, exp_ops[idx]);
                else
                    chk({name, "_op_extra"}, 1'b1, 1'b0);
                if (idx >= 5 * N && idx < 9 * N && mem_rden)
                    chk($sformatf("%s_desc%0d", name, idx), mem_addr, N - 1 - (((idx - 5 * N) / 2) % N));
                idx++;
            end else begin
                chk({name, "_idle_zero"}, {mem_wren, mem_rden, mem_addr, mem_wdata}, 78'd0);
            end
            if (done) dones++;
            if (busy_cycles > 0 && !busy && !done) begin
                finished = 1;
                break;
            end
            start = poke_start && (busy_cycles == 10 || busy_cycles == 100);
            if (abort_at > 0 && busy_cycles == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk({name, "_abort_zero"}, {busy, done, pass, mem_wren, mem_rden, mem_addr, mem_wdata, err_addr, err_count}, 0);
                rst = 1'b0;
                seen = 0;
                for (int j = 0; j < 200; j++) begin
                    @(negedge clk);
                    if (done || busy) seen++;
                end
                chk({name, "_abort_no_done"}, seen, 0);
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, "_finished"}, finished, 1'b1);
        chk({name, "_busy_cycles"}, busy_cycles, 10 * N + 1);
        chk({name, "_done_pulses"}, dones, 1);
        chk({name, "_pass"}, pass, nerr == 0);
`ifdef BIST_ERRLOG_EN
        exp_cnt = 16'(nerr);
        exp_ea  = (nerr > 0) ? first : '0;
`else
        exp_cnt = '0;
        exp_ea  = '0;
`endif
        chk({name, "_err_count"}, err_count, exp_cnt);
        chk({name, "_err_addr"}, err_addr, exp_ea);
        $display("run %s: faults=%0d busy=%0d pass=%0b err_count=%0d err_addr=%0d", name, nerr, busy_cycles, pass, err_count, err_addr);
    endtask

    initial begin
        for (int k = 0; k < N; k++) ram[k] = {$urandom, $urandom, $urandom};
        mem_rdata = '0;
        fault_en = 1'b0; fault_addr = '0; fault_bit = 0; fault_val = 1'b0;
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_zero", {busy, done, pass, mem_wren, mem_rden, mem_addr, mem_wdata, err_addr, err_count}, 0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", busy, 1'b0);

        do_run("clean", 0, 0);

        fault_en = 1'b1; fault_addr = 4'd3; fault_bit = 5; fault_val = 1'b1;
        do_run("sa1_a3_b5", 0, 0);

        fault_en = 1'b0;
        do_run("abort50", 50, 0);
        do_run("after_abort", 0, 0);
        do_run("poke_start", 0, 1);

        for (int r = 0; r < 6; r++) begin
            fault_en   = 1'($urandom_range(0, 3) != 0);
            fault_addr = ABITS'($urandom_range(0, N - 1));
            fault_bit  = int'($urandom_range(0, WIDTH - 1));
            fault_val  = 1'($urandom_range(0, 1));
            do_run($sformatf("rand%0d", r), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_march_bist.md
MEM_MARCH_BIST -- requirements
Module: mem_march_bist

Interface
- REQ-001: The block SHALL have parameter ABITS, default 12, memory address width; the tested depth is N = 2**ABITS.
- REQ-002: The block SHALL have parameter WIDTH, default 72, memory data width.
- REQ-003: The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
- REQ-004: The block SHALL have port rst, input, 1, synchronous active-high reset.
- REQ-005: The block SHALL have port start, input, 1, which requests a test run.
- REQ-006: The block SHALL have port busy, output, 1, asserted while a run is in progress.
- REQ-007: The block SHALL have port done, output, 1, a one-cycle pulse at run end.
- REQ-008: The block SHALL have port pass, output, 1, the result of the last run.
- REQ-009: The block SHALL have ports mem_wren, mem_rden, output, 1 each, the memory port enables.
- REQ-010: The block SHALL have port mem_addr, output, ABITS, the memory address.
- REQ-011: The block SHALL have port mem_wdata, output, WIDTH, the memory write data.
- REQ-012: The block SHALL have port mem_rdata, input, WIDTH, read data registered by the memory, valid one cycle after a mem_rden cycle.
- REQ-013: The block SHALL have port err_addr, output, ABITS, the first failing address.
- REQ-014: The block SHALL have port err_count, output, 16, the count of mismatches.

Function
- REQ-015: The block SHALL be the initiator for a single read-first synchronous RAM port and SHALL never assert mem_wren and mem_rden in the same cycle.
- REQ-016: The block SHALL accept start only in IDLE; start while busy=1 SHALL be ignored.
- REQ-017: The FSM SHALL have states IDLE, M0..M5, FIN; a start accepted in IDLE SHALL set busy=1 and present the first memory op in the following cycle.
- REQ-018: M0 SHALL write all-zeros to addresses 0..N-1, one per cycle, ascending.
- REQ-019: M1 (ascending, r0 w1), M2 (ascending, r1 w0), M3 (descending, r0 w1) and M4 (descending, r1 w0) SHALL each spend two cycles per address: cycle A asserts mem_rden; cycle B asserts mem_wren at the same address and compares mem_rdata with the expected pattern.
- REQ-020: M5 SHALL read all-zeros ascending, one address per cycle, and compare each read one cycle later.
- REQ-021: The expected pattern SHALL be all-zeros ("0") or all-ones ("1") across the full WIDTH.
- REQ-022: The address counter SHALL wrap from N-1 to 0 (ascending) or 0 to N-1 (descending) exactly at an element boundary, with no idle cycle between elements.
- REQ-023: FIN SHALL perform the last M5 compare; busy SHALL be high for exactly 10N+1 cycles.
- REQ-024: After FIN the block SHALL return to IDLE with busy=0 and done=1 for exactly one cycle.
- REQ-025: pass SHALL be 1 at done when no mismatch occurred and 0 otherwise; it SHALL hold until the next accepted start, which clears it to 0.
- REQ-026: mem_wren, mem_rden, mem_addr and mem_wdata SHALL be 0 whenever busy=0.

Reset
- REQ-027: On rst=1 at a clock edge, the block SHALL enter IDLE and drive busy, done, pass, mem_wren, mem_rden, mem_addr, mem_wdata, err_addr and err_count to 0.
- REQ-028: A reset asserted mid-run SHALL abort the run with no done pulse, and rst SHALL take priority over start.

Configuration
- REQ-029: When macro BIST_ERRLOG_EN is defined, err_count SHALL increment per mismatching compare, saturate at 0xFFFF and clear on accepted start, and err_addr SHALL capture the address of the first mismatch of the run.
- REQ-030: When BIST_ERRLOG_EN is undefined, err_addr and err_count SHALL remain present but tied to 0, and pass/done behaviour SHALL be unchanged.

Verification
- REQ-031: With ABITS=4 and a fault-free model, one start pulse SHALL give busy high 161 cycles, then done=1 and pass=1, with err_count=0.
- REQ-032: With a stuck-at-1 bit 5 at address 3, the run SHALL end with pass=0, err_addr=3 and err_count=3 (mismatches in M1, M3 and M5) when BIST_ERRLOG_EN is defined.
- REQ-033: Asserting rst at cycle 50 of a run SHALL give all outputs 0 the next cycle, no done pulse, and a fresh start that completes normally.
- REQ-034: A start pulsed at cycles 10 and 100 of a run SHALL have no effect, giving exactly one done pulse at cycle 161.
- REQ-035: The bench SHALL check every busy cycle for no mem_wren&&mem_rden overlap and check the descending address order 15..0 in M3 and M4.
